// File: rtl/clk_meas_pkg.sv
// Shared definitions for the clock period meter: FSM encoding and synchronizer depth.
package clk_meas_pkg;

  typedef enum logic [0:0] {
    StIdle    = 1'b0,
    StMeasure = 1'b1
  } meas_state_e;

  localparam int unsigned SyncDepth = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer followed by a registered rise/fall detector.
// Every edge sees the same latency, so widths measured between edges are exact.
module sync_edge_det
  import clk_meas_pkg::*;
(
  input  logic clk_in,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise,
  output logic fall,
  output logic level
);

  logic [SyncDepth-1:0] sync_q;
  logic                 prev_q;
  logic                 rise_q;
  logic                 fall_q;

  // Synchronize, remember the previous level and register the edge strobes.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SyncDepth-2:0], sig_in};
      prev_q <= sync_q[SyncDepth-1];
      rise_q <= sync_q[SyncDepth-1] & ~prev_q;
      fall_q <= ~sync_q[SyncDepth-1] & prev_q;
    end
  end

  // prev_q is aligned with the registered strobes, so it is the matching level.
  assign rise  = rise_q;
  assign fall  = fall_q;
  assign level = prev_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures the period (and optionally high time) of a slow asynchronous input in clk_in
// cycles and hands results out over a valid/ready handshake.
// Optional feature: define CLK_PERIOD_METER_DUTY_EN to build the high_time port and logic.
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int unsigned CNT_W = 20
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period,
`ifdef CLK_PERIOD_METER_DUTY_EN
  output logic [CNT_W-1:0] high_time,
`endif
  output logic             timeout,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic rise, fall, level;

  sync_edge_det u_sync_edge_det (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .sig_in (sig_in),
    .rise   (rise),
    .fall   (fall),
    .level  (level)
  );

  meas_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             timeout_q, timeout_d;
  logic             capture;
  logic             load;

  // Period FSM: arm on the first rise, then capture on each later rise or time out.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (rise) begin
          state_d = StMeasure;
          cnt_d   = CntOne;
        end
      end
      StMeasure: begin
        // A rise on the terminal count still captures; timeout only without one.
        if (rise) begin
          capture = 1'b1;
          cnt_d   = CntOne;
        end else if (cnt_q == CntMax) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A new result may replace the held one only if it is being consumed this cycle.
  assign load = capture & (~valid_q | meas_ready);

  // Result register, handshake and sticky overrun.
  always_comb begin
    valid_d   = valid_q & ~meas_ready;
    period_d  = period_q;
    overrun_d = overrun_q;
    if (valid_q & meas_ready) overrun_d = 1'b0;
    if (load) begin
      valid_d  = 1'b1;
      period_d = cnt_q;
    end else if (capture) begin
      overrun_d = 1'b1;
    end
  end

  // State and result registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  assign meas_valid = valid_q;
  assign period     = period_q;
  assign overrun    = overrun_q;
  assign timeout    = timeout_q;

`ifdef CLK_PERIOD_METER_DUTY_EN
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             high_run_q, high_run_d;

  // High-time counter: restart on rise, count while high, freeze on fall.
  always_comb begin
    high_cnt_d  = high_cnt_q;
    high_run_d  = high_run_q;
    high_time_d = high_time_q;
    if (rise) begin
      high_cnt_d = CntOne;
      high_run_d = 1'b1;
    end else if (fall) begin
      high_run_d = 1'b0;
    end else if (high_run_q && level) begin
      high_cnt_d = high_cnt_q + CntOne;
    end
    if (timeout_d) begin
      high_cnt_d = '0;
      high_run_d = 1'b0;
    end
    if (load) high_time_d = high_cnt_q;
  end

  // High-time registers.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      high_cnt_q  <= '0;
      high_run_q  <= 1'b0;
      high_time_q <= '0;
    end else begin
      high_cnt_q  <= high_cnt_d;
      high_run_q  <= high_run_d;
      high_time_q <= high_time_d;
    end
  end

  assign high_time = high_time_q;
`else
  logic unused_fall_level;
  assign unused_fall_level = fall ^ level;
`endif

endmodule
